jk_univ_reg: RTL and testbench

JK_UNIV_REG -- requirements
Module: jk_univ_reg

---
 rtl/jk_univ_reg.sv | 109 ++++++++++
 tb/tb_jk_univ_reg.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/jk_univ_reg.sv
// ---------------------------------------------------------------------------
// jk_univ_reg -- universal register with four operating modes
//
// A WIDTH-bit register that behaves as a bank of independent JK flip-flops,
// an up/down counter, a bidirectional shift register, or a parallel-load
// register, depending on 'mode'. All state updates on posedge clk.
//
// Parameters
//   WIDTH      register width in bits (2..32)
//   RESET_VAL  value loaded into Q on synchronous reset
//
// Ports
//   clk         in   clock
//   sync_reset  in   synchronous active-high reset (highest priority)
//   en          in   update enable; 0 holds Q and forces tc low
//   mode        in   2'b00 JK, 2'b01 COUNT, 2'b10 SHIFT, 2'b11 LOAD
//   dir         in   COUNT: 0 up / 1 down; SHIFT: 0 left / 1 right
//   J, K        in   per-bit JK controls (JK mode only)
//   d           in   parallel load data (LOAD mode only)
//   serial_in   in   bit shifted in (SHIFT mode only)
//   Q           out  register state
//   tc          out  registered one-cycle pulse after a COUNT wrap
//   serial_out  out  combinational; the bit the next SHIFT edge discards
// ---------------------------------------------------------------------------
module jk_univ_reg #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             sync_reset,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             dir,
  input  logic [WIDTH-1:0] J,
  input  logic [WIDTH-1:0] K,
  input  logic [WIDTH-1:0] d,
  input  logic             serial_in,
  output logic [WIDTH-1:0] Q,
  output logic             tc,
  output logic             serial_out
);

  typedef enum logic [1:0] {
    MODE_JK    = 2'b00,
    MODE_COUNT = 2'b01,
    MODE_SHIFT = 2'b10,
    MODE_LOAD  = 2'b11
  } mode_e;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] q_q, q_d;
  logic             tc_q, tc_d;

  // Next-state logic. Each mode reads only the inputs it owns, so an
  // unused input that is X cannot reach Q or tc.
  always_comb begin
    // NOTE: every output of this block gets a default first; a path that
    // leaves one unassigned would infer a latch.
    q_d  = q_q;
    tc_d = 1'b0;
    if (en) begin
      case (mode_e'(mode))
        // Per bit: 00 hold, 01 clear, 10 set, 11 toggle.
        MODE_JK: q_d = (q_q & ~K) | (~q_q & J);

        // Natural modulo-2^WIDTH wrap; tc flags the wrap for one cycle.
        MODE_COUNT: begin
          if (dir) begin
            q_d  = q_q - ONE;
            tc_d = (q_q == '0);
          end else begin
            q_d  = q_q + ONE;
            tc_d = &q_q;
          end
        end

        MODE_SHIFT: begin
          if (dir) q_d = {serial_in, q_q[WIDTH-1:1]};
          else     q_d = {q_q[WIDTH-2:0], serial_in};
        end

        MODE_LOAD: q_d = d;

        default: q_d = q_q;
      endcase
    end
  end

  // Reset wins over enable and mode.
  always_ff @(posedge clk) begin
    // NOTE: state flops use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    if (sync_reset) begin
      q_q  <= RESET_VAL;
      tc_q <= 1'b0;
    end else begin
      q_q  <= q_d;
      tc_q <= tc_d;
    end
  end

  assign Q          = q_q;
  assign tc         = tc_q;
  // Bit leaving the register on the next shift, so a downstream instance
  // can take it straight into its serial_in.
  assign serial_out = dir ? q_q[0] : q_q[WIDTH-1];

endmodule

// File: tb/tb_jk_univ_reg.sv
// ---------------------------------------------------------------------------
// tb_jk_univ_reg -- self-checking bench for jk_univ_reg
//
// Two 4-bit instances share all inputs: dut0 resets to 0000, dut1 to 0101.
// A behavioural model (integer arithmetic) tracks both; a compare process
// checks Q, tc and serial_out every cycle once a reset has been seen.
// A directed phase pins the model with hand-computed literals, then a
// randomized phase exercises all modes, enable and reset.
// ---------------------------------------------------------------------------
module tb_jk_univ_reg;

  localparam int W    = 4;
  localparam int M    = 1 << W;
  localparam int RV0  = 0;
  localparam int RV1  = 5;

  logic         clk = 1'b0;
  logic         sync_reset = 1'b0;
  logic         en = 1'b0;
  logic [1:0]   mode = 2'b00;
  logic         dir = 1'b0;
  logic [W-1:0] J = '0, K = '0, d = '0;
  logic         serial_in = 1'b0;

  logic [W-1:0] q0, q1;
  logic         tc0, tc1, so0, so1;

  int checks = 0;
  int errors = 0;

  // Model state
  int  m_q0, m_q1;
  bit  m_tc0, m_tc1;
  bit  m_valid = 1'b0;

  always #5 clk = ~clk;

  jk_univ_reg #(.WIDTH(W), .RESET_VAL(4'b0000)) dut0 (
    .clk(clk), .sync_reset(sync_reset), .en(en), .mode(mode), .dir(dir),
    .J(J), .K(K), .d(d), .serial_in(serial_in),
    .Q(q0), .tc(tc0), .serial_out(so0)
  );

  jk_univ_reg #(.WIDTH(W), .RESET_VAL(4'b0101)) dut1 (
    .clk(clk), .sync_reset(sync_reset), .en(en), .mode(mode), .dir(dir),
    .J(J), .K(K), .d(d), .serial_in(serial_in),
    .Q(q1), .tc(tc1), .serial_out(so1)
  );

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Next value of one model register under the current inputs.
  function automatic void model_step(input int rv, inout int q, inout bit tcv);
    int jj = int'(J), kk = int'(K), sin = int'(serial_in);
    tcv = 1'b0;
    if (sync_reset) begin
      q = rv;
    end else if (en) begin
      case (mode)
        2'b00: begin
          // set where only J, clear where only K, then toggle where both
          q = (q | (jj & ~kk)) & ~(kk & ~jj);
          q = q ^ (jj & kk);
          q = q & (M - 1);
        end
        2'b01: begin
          if (dir) begin tcv = (q == 0);     q = (q + M - 1) % M; end
          else     begin tcv = (q == M - 1); q = (q + 1) % M;     end
        end
        2'b10: begin
          if (dir) q = (q >> 1) + sin * (M / 2);
          else     q = (q * 2 + sin) % M;
        end
        default: q = int'(d);
      endcase
    end
  endfunction

  always @(posedge clk) begin
    model_step(RV0, m_q0, m_tc0);
    model_step(RV1, m_q1, m_tc1);
    if (sync_reset) m_valid = 1'b1;
  end

  // Compare process: late in the low phase, inputs and outputs are settled.
  always @(negedge clk) begin
    #3;
    if (m_valid) begin
      check("q0", int'(q0), m_q0);
      check("tc0", int'(tc0), int'(m_tc0));
      check("q1", int'(q1), m_q1);
      check("tc1", int'(tc1), int'(m_tc1));
      check("so0", int'(so0), dir ? (m_q0 % 2) : (m_q0 / (M / 2)));
      check("so1", int'(so1), dir ? (m_q1 % 2) : (m_q1 / (M / 2)));
    end
  end

  // Apply one set of inputs across one edge, then return just after it.
  task automatic apply(input bit r, input bit e, input logic [1:0] md, input bit dr,
                       input logic [W-1:0] jv, input logic [W-1:0] kv,
                       input logic [W-1:0] dv, input bit si);
    @(negedge clk);
    sync_reset = r; en = e; mode = md; dir = dr;
    J = jv; K = kv; d = dv; serial_in = si;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset
    apply(1, 0, 2'b00, 0, '0, '0, '0, 0);
    check("rst_q0", int'(q0), 0);
    check("rst_tc0", int'(tc0), 0);
    check("rst_q1", int'(q1), 5);

    // JK: 1010/0110 -> set b3, clear b2, toggle b1, hold b0
    apply(0, 1, 2'b00, 0, 4'b1010, 4'b0110, 4'b1111, 1);
    check("jk1", int'(q0), 4'b1010);
    apply(0, 1, 2'b00, 0, 4'b1010, 4'b0110, 4'b1111, 1);
    check("jk2", int'(q0), 4'b1000);

    // COUNT up through wrap
    apply(0, 1, 2'b11, 0, '1, '1, 4'b1110, 1);
    check("load", int'(q0), 4'b1110);
    apply(0, 1, 2'b01, 0, '1, '1, '0, 1);
    check("up1_q", int'(q0), 4'b1111);
    check("up1_tc", int'(tc0), 0);
    apply(0, 1, 2'b01, 0, '1, '1, '0, 1);
    check("up2_q", int'(q0), 4'b0000);
    check("up2_tc", int'(tc0), 1);
    apply(0, 1, 2'b01, 0, '1, '1, '0, 1);
    check("up3_q", int'(q0), 4'b0001);
    check("up3_tc", int'(tc0), 0);

    // COUNT down through wrap
    apply(0, 1, 2'b01, 1, '0, '0, '0, 0);
    check("dn1_q", int'(q0), 4'b0000);
    check("dn1_tc", int'(tc0), 0);
    apply(0, 1, 2'b01, 1, '0, '0, '0, 0);
    check("dn2_q", int'(q0), 4'b1111);
    check("dn2_tc", int'(tc0), 1);
    apply(0, 1, 2'b01, 1, '0, '0, '0, 0);
    check("dn3_q", int'(q0), 4'b1110);
    check("dn3_tc", int'(tc0), 0);

    // SHIFT right then left
    apply(0, 1, 2'b11, 0, '0, '0, 4'b1011, 0);
    @(negedge clk);
    mode = 2'b10; dir = 1'b1; serial_in = 1'b0; d = 4'b0000;
    #1;
    check("so_pre", int'(so0), 1);
    @(posedge clk);
    #1;
    check("shr_q", int'(q0), 4'b0101);
    check("shr_so", int'(so0), 1);
    apply(0, 1, 2'b10, 0, '1, '1, '0, 1);
    check("shl_q", int'(q0), 4'b1011);

    // Hold with en=0 in every mode, then reset beats en=0
    apply(0, 1, 2'b11, 0, '0, '0, 4'b0110, 0);
    for (int i = 0; i < 4; i++) begin
      apply(0, 0, 2'(i), 1'(i), '1, '0, 4'b1001, 1);
      check("hold_q", int'(q0), 4'b0110);
      check("hold_tc", int'(tc0), 0);
    end
    apply(1, 0, 2'b01, 0, '0, '0, '0, 0);
    check("rst_en0", int'(q0), 0);

    // Reset on a wrap edge aborts the count and suppresses tc
    apply(0, 1, 2'b11, 0, '0, '0, 4'b1111, 0);
    apply(1, 1, 2'b01, 0, '0, '0, '0, 0);
    check("rmid_q1", int'(q1), 4'b0101);
    check("rmid_tc1", int'(tc1), 0);
    apply(0, 1, 2'b01, 0, '0, '0, '0, 0);
    check("rrel_q1", int'(q1), 4'b0110);

    // Randomized phase
    for (int n = 0; n < 2000; n++) begin
      apply(($urandom_range(31) == 0), ($urandom_range(7) != 0),
            2'($urandom), 1'($urandom), W'($urandom), W'($urandom),
            W'($urandom), 1'($urandom));
    end

    @(negedge clk);
    #4;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
